// File: rtl/spi_target_sync.sv
// SPI target that runs entirely on clk: sclk/mosi/cs are synchronized and sclk edges
// are detected, so no logic is clocked by sclk. Byte-wide rx_valid / tx_ack handshake.
module spi_target_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CPOL,
  input  logic       CPHA,
  input  logic       sclk_pin,
  input  logic       mosi_pin,
  input  logic       cs_pin,
  output logic       miso_pin,
  output logic       miso_oe,
  input  logic [7:0] tx_data,
  output logic       tx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s;
  logic mosi_s;
  logic cs_s;
  logic sclk_chg;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic launch_edge;
  logic cs_fall;

  state_t     state_q;
  logic [7:0] tx_shift_q;
  logic [7:0] rx_shift_q;
  logic [7:0] rx_data_q;
  logic [2:0] bit_cnt_q;
  logic       skip_q;
  logic       tx_ack_q;
  logic       rx_valid_q;
  logic       frame_err_q;
  logic       busy_q;

  // Sync chains idle as "deselected, sclk low".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_pin};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_pin};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_pin};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sclk_chg    = sclk_s ^ sclk_prev_q;
  assign lead_edge   = sclk_chg & (sclk_s != CPOL);
  assign trail_edge  = sclk_chg & (sclk_s == CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign launch_edge = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = cs_prev_q & ~cs_s;

  // skip_q swallows the one launch edge that would clobber a freshly loaded MSB:
  // the 8th trailing edge for CPHA=0, the first leading edge of each byte for CPHA=1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      rx_data_q   <= 8'h00;
      bit_cnt_q   <= 3'd0;
      skip_q      <= 1'b0;
      tx_ack_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tx_ack_q    <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (cs_fall) begin
            state_q <= ST_LOAD;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (cs_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            tx_shift_q <= tx_data;
            tx_ack_q   <= 1'b1;
            bit_cnt_q  <= 3'd0;
            skip_q     <= CPHA;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            if (bit_cnt_q != 3'd0) begin
              frame_err_q <= 1'b1;
            end
          end else if (sample_edge) begin
            rx_shift_q <= {rx_shift_q[6:0], mosi_s};
            if (bit_cnt_q == 3'd7) begin
              rx_data_q  <= {rx_shift_q[6:0], mosi_s};
              rx_valid_q <= 1'b1;
              tx_shift_q <= tx_data;
              tx_ack_q   <= 1'b1;
              bit_cnt_q  <= 3'd0;
              skip_q     <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else if (launch_edge) begin
            if (skip_q) begin
              skip_q <= 1'b0;
            end else begin
              tx_shift_q <= {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign miso_pin  = busy_q & tx_shift_q[7];
  assign miso_oe   = busy_q;
  assign busy      = busy_q;
  assign tx_ack    = tx_ack_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_target_sync.sv
// Randomized bench for spi_target_sync: a bit-banged SPI master plus fabric model,
// with a scoreboard of expected received bytes checked by a monitor process.
module tb_spi_target_sync;
  localparam int SS = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       CPOL = 1'b0;
  logic       CPHA = 1'b0;
  logic       sclk_pin = 1'b0;
  logic       mosi_pin = 1'b0;
  logic       cs_pin = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       miso_pin;
  logic       miso_oe;
  logic       tx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  spi_target_sync #(.SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .CPOL(CPOL), .CPHA(CPHA),
    .sclk_pin(sclk_pin), .mosi_pin(mosi_pin), .cs_pin(cs_pin),
    .miso_pin(miso_pin), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int rxv_cnt = 0;
  int ferr_cnt = 0;
  bit desel_mon = 1'b0;
  bit load_req = 1'b0;
  logic [7:0] exp_rx[$];
  logic [7:0] fab_q[$];
  logic [7:0] ms[$];
  logic [7:0] ft[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor + fabric: pops expected rx bytes, serves tx_data on each tx_ack.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        rxv_cnt++;
        if (exp_rx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got rx_valid with 0x%0h, expected no pulse", rx_data);
        end else begin
          check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
        end
      end
      if (frame_err) ferr_cnt++;
      if (load_req) begin
        tx_data  = (fab_q.size() > 0) ? fab_q.pop_front() : 8'h00;
        load_req = 1'b0;
      end else if (tx_ack) begin
        ack_cnt++;
        tx_data = (fab_q.size() > 0) ? fab_q.pop_front() : 8'($urandom);
      end
      if (desel_mon) begin
        check("desel_miso_oe", {31'h0, miso_oe}, 32'h0);
        check("desel_miso_pin", {31'h0, miso_pin}, 32'h0);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic hwait(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_miso_oe"}, {31'h0, miso_oe}, 32'h0);
    check({tag, "_miso_pin"}, {31'h0, miso_pin}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_tx_ack"}, {31'h0, tx_ack}, 32'h0);
    check({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'h0);
    check({tag, "_frame_err"}, {31'h0, frame_err}, 32'h0);
    check({tag, "_rx_data"}, {24'h0, rx_data}, 32'h0);
  endtask

  // kind 0: cs rises after `limit` sample edges; kind 1: reset asserted instead.
  task automatic do_frame(input int mode, input int half, input int limit, input int kind);
    int cnt = 0;
    int nfull;
    bit stop = 1'b0;
    logic [7:0] r;
    logic [7:0] mrx[$];
    CPOL = mode[1];
    CPHA = mode[0];
    sclk_pin = CPOL;
    hwait(4);
    fab_q = ft;
    load_req = 1'b1;
    hwait(3);
    ack_cnt = 0;
    rxv_cnt = 0;
    ferr_cnt = 0;
    nfull = (limit >= 8 * ms.size()) ? ms.size() : limit / 8;
    for (int k = 0; k < nfull; k++) exp_rx.push_back(ms[k]);
    cs_pin = 1'b0;
    hwait(SS + 6);
    for (int b = 0; b < ms.size() && !stop; b++) begin
      r = 8'h00;
      for (int i = 7; i >= 0 && !stop; i--) begin
        if (CPHA == 1'b0) begin
          mosi_pin = ms[b][i];
          hwait(half);
          sclk_pin = ~CPOL;
          r = {r[6:0], miso_pin};
          hwait(half);
          sclk_pin = CPOL;
        end else begin
          hwait(half);
          sclk_pin = ~CPOL;
          mosi_pin = ms[b][i];
          hwait(half);
          sclk_pin = CPOL;
          r = {r[6:0], miso_pin};
        end
        cnt++;
        if (cnt == limit) stop = 1'b1;
      end
      if (cnt == 8 * (b + 1)) mrx.push_back(r);
    end
    if (kind == 1 && stop) begin
      hwait(2);
      rst_n = 1'b0;
      #1;
      outputs_zero("reset_mid");
      cs_pin = 1'b1;
      sclk_pin = CPOL;
      hwait(5);
      rst_n = 1'b1;
      hwait(10);
    end else begin
      hwait(half);
      cs_pin = 1'b1;
      repeat (SS + 2) @(posedge clk);
      #1;
      check("end_busy", {31'h0, busy}, 32'h0);
      check("end_miso_oe", {31'h0, miso_oe}, 32'h0);
      hwait(10);
    end
    check("master_rx_count", mrx.size(), nfull);
    for (int k = 0; k < nfull && k < mrx.size(); k++)
      check("master_rx", {24'h0, mrx[k]}, {24'h0, ft[k]});
    check("rx_valid_count", rxv_cnt, nfull);
    check("tx_ack_count", ack_cnt, nfull + 1);
    check("frame_err_count", ferr_cnt, (kind == 0 && stop && (limit % 8) != 0) ? 1 : 0);
    check("rx_missing", exp_rx.size(), 0);
    if (kind == 0 && nfull > 0)
      check("rx_data_held", {24'h0, rx_data}, {24'h0, ms[nfull-1]});
    exp_rx.delete();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    outputs_zero("reset");
    hwait(1);
    rst_n = 1'b1;
    hwait(5);

    ms = '{8'h5A}; ft = '{8'hC3};
    do_frame(0, 6, 1000, 0);
    for (int m = 1; m < 4; m++) begin
      ms = '{8'h3C}; ft = '{8'hA5};
      do_frame(m, 6, 1000, 0);
    end
    ms = '{8'h01, 8'h02, 8'h03}; ft = '{8'h10, 8'h20, 8'h30};
    do_frame(0, 7, 1000, 0);
    ms = '{8'h01, 8'h02, 8'h03}; ft = '{8'h10, 8'h20, 8'h30};
    do_frame(3, 6, 1000, 0);
    ms = '{8'hFF}; ft = '{8'h99};
    do_frame(0, 6, 3, 0);
    ms = '{8'h77}; ft = '{8'h5E};
    do_frame(0, 6, 1000, 0);
    ms = '{8'hFF}; ft = '{8'h81};
    do_frame(1, 6, 5, 1);
    ms = '{8'hE1}; ft = '{8'h3D};
    do_frame(1, 6, 1000, 0);

    // deselected: pins wiggle, target must stay silent
    ack_cnt = 0; rxv_cnt = 0; ferr_cnt = 0;
    desel_mon = 1'b1;
    for (int i = 0; i < 120; i++) begin
      sclk_pin = 1'($urandom);
      mosi_pin = 1'($urandom);
      hwait(1 + $urandom_range(0, 3));
    end
    desel_mon = 1'b0;
    sclk_pin = CPOL;
    hwait(10);
    check("desel_rx_valid", rxv_cnt, 0);
    check("desel_tx_ack", ack_cnt, 0);
    check("desel_frame_err", ferr_cnt, 0);

    for (int f = 0; f < 24; f++) begin
      int n;
      int lim;
      n = $urandom_range(1, 3);
      ms.delete(); ft.delete();
      for (int k = 0; k < n; k++) begin
        ms.push_back(8'($urandom));
        ft.push_back(8'($urandom));
      end
      lim = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 8 * n - 1) : 1000;
      do_frame($urandom_range(0, 3), $urandom_range(6, 9), lim, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
